// File: rtl/rv_skid_pipe.sv
// Two-entry valid/ready skid stage: registered in_ready isolates the producer from out_ready.
// Optional synchronous flush port and logic enabled by defining RV_SKID_FLUSH_EN.
module rv_skid_pipe #(
  parameter int unsigned WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
`ifdef RV_SKID_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             push;
  logic             pop;
  logic             clear;

  // in_ready depends only on state and reset, never on out_ready
  assign in_ready  = ~skid_valid & ~rst;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign count     = {1'b0, main_valid} + {1'b0, skid_valid};

  assign push = in_valid & in_ready;
  assign pop  = main_valid & out_ready;

`ifdef RV_SKID_FLUSH_EN
  assign clear = flush;
`else
  assign clear = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (clear) begin
      // Data registers keep stale contents; only the valid bits drop
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (pop) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end
    end else begin
      if (push && (!main_valid || pop)) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end else if (push) begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end else if (pop) begin
        main_valid <= 1'b0;
      end
    end
  end

endmodule
